// File: rtl/motion_region_tracker_if.sv
// Bundle between the frame-difference comparator, the motion tracker and the
// result consumer (overlay / LEDs). The master side is the tracker.
interface motion_region_tracker_if #(
  parameter int CW = 19
);
  logic          frame_start;
  logic          pixel_valid;
  logic          motion_flag;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] motion_count;
  logic [9:0]    box_x_min;
  logic [9:0]    box_x_max;
  logic [8:0]    box_y_min;
  logic [8:0]    box_y_max;
  logic          box_valid;
  logic          motion_alarm;
  logic          overrun;

  modport master (
    input  frame_start, pixel_valid, motion_flag, result_ready,
    output result_valid, motion_count, box_x_min, box_x_max,
           box_y_min, box_y_max, box_valid, motion_alarm, overrun
  );

  modport slave (
    output frame_start, pixel_valid, motion_flag, result_ready,
    input  result_valid, motion_count, box_x_min, box_x_max,
           box_y_min, box_y_max, box_valid, motion_alarm, overrun
  );
endinterface

// File: rtl/motion_region_tracker.sv
// Per-frame motion statistics: moving-pixel count, bounding box and a
// debounced alarm, reported through a valid/ready result port.
module motion_region_tracker #(
  parameter int         H_ACT           = 640,
  parameter int         V_ACT           = 480,
  parameter logic [18:0] COUNT_THRESHOLD = 19'd200,
  parameter logic [3:0] HOLD_FRAMES     = 4'd8,
  parameter int         CW              = $clog2(H_ACT*V_ACT+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  motion_region_tracker_if.master bus
);

  localparam logic [9:0]    X_LAST  = 10'(H_ACT - 1);
  localparam logic [8:0]    Y_LAST  = 9'(V_ACT - 1);
  localparam logic [CW-1:0] PIX_MAX = CW'(H_ACT * V_ACT);

  typedef enum logic {WAIT_SOF, ACCUM} state_t;

  state_t state, state_next;
  logic   clear, accum, commit;

  // Working registers for the frame in progress
  logic [CW-1:0] cnt;
  logic [9:0]    x, xmin, xmax;
  logic [8:0]    y, ymin, ymax;

  // Result registers
  logic          res_valid;
  logic [CW-1:0] res_count;
  logic [9:0]    res_x_min, res_x_max;
  logic [8:0]    res_y_min, res_y_max;
  logic          res_box_valid;
  logic          res_overrun;
  logic          alarm;
  logic [3:0]    hold;

  logic          last_pix;
  logic [CW-1:0] cnt_upd;
  logic [9:0]    xmin_upd, xmax_upd;
  logic [8:0]    ymin_upd, ymax_upd;
  logic          motion_frame;

  assign last_pix = bus.pixel_valid && (x == X_LAST) && (y == Y_LAST);

  // Working registers merged with the current pixel, so the final pixel of a
  // frame lands in the committed result on the same edge it is sampled.
  assign cnt_upd  = (bus.motion_flag && cnt != PIX_MAX) ? cnt + CW'(1) : cnt;
  assign xmin_upd = (bus.motion_flag && x < xmin) ? x : xmin;
  assign xmax_upd = (bus.motion_flag && x > xmax) ? x : xmax;
  assign ymin_upd = (bus.motion_flag && y < ymin) ? y : ymin;
  assign ymax_upd = (bus.motion_flag && y > ymax) ? y : ymax;

  assign motion_frame = 32'(cnt_upd) > 32'(COUNT_THRESHOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register is written with <= so all state updates see the
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state <= WAIT_SOF;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers latches for the unassigned branches.
    state_next = state;
    clear      = 1'b0;
    accum      = 1'b0;
    commit     = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (bus.frame_start) begin
          state_next = ACCUM;
          clear      = 1'b1;
        end
      end
      ACCUM: begin
        if (last_pix) begin
          commit = 1'b1;
          accum  = 1'b1;
          // A frame_start on the last pixel commits and restarts at once
          if (bus.frame_start) clear = 1'b1;
          else                 state_next = WAIT_SOF;
        end else if (bus.frame_start) begin
          clear = 1'b1;
        end else if (bus.pixel_valid) begin
          accum = 1'b1;
        end
      end
      default: state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      x    <= '0;
      y    <= '0;
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
    end else if (clear) begin
      cnt  <= '0;
      x    <= '0;
      y    <= '0;
      xmin <= X_LAST;
      xmax <= '0;
      ymin <= Y_LAST;
      ymax <= '0;
    end else if (accum) begin
      cnt  <= cnt_upd;
      xmin <= xmin_upd;
      xmax <= xmax_upd;
      ymin <= ymin_upd;
      ymax <= ymax_upd;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 9'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= 1'b0;
      res_count     <= '0;
      res_x_min     <= '0;
      res_x_max     <= '0;
      res_y_min     <= '0;
      res_y_max     <= '0;
      res_box_valid <= 1'b0;
      res_overrun   <= 1'b0;
    end else if (commit) begin
      res_valid     <= 1'b1;
      res_count     <= cnt_upd;
      res_box_valid <= (cnt_upd != '0);
      res_x_min     <= (cnt_upd != '0) ? xmin_upd : '0;
      res_x_max     <= (cnt_upd != '0) ? xmax_upd : '0;
      res_y_min     <= (cnt_upd != '0) ? ymin_upd : '0;
      res_y_max     <= (cnt_upd != '0) ? ymax_upd : '0;
      if (res_valid && !bus.result_ready) res_overrun <= 1'b1;
    end else if (res_valid && bus.result_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Alarm debounce advances once per committed frame, regardless of handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      alarm <= 1'b0;
    end else if (commit) begin
      if (motion_frame) begin
        hold  <= HOLD_FRAMES;
        alarm <= 1'b1;
      end else if (hold != '0) begin
        hold  <= hold - 4'd1;
        alarm <= (hold != 4'd1);
      end else begin
        alarm <= 1'b0;
      end
    end
  end

  assign bus.result_valid = res_valid;
  assign bus.motion_count = res_count;
  assign bus.box_x_min    = res_x_min;
  assign bus.box_x_max    = res_x_max;
  assign bus.box_y_min    = res_y_min;
  assign bus.box_y_max    = res_y_max;
  assign bus.box_valid    = res_box_valid;
  assign bus.motion_alarm = alarm;
  assign bus.overrun      = res_overrun;

endmodule

// File: tb/tb_motion_region_tracker.sv
// Scoreboard bench for motion_region_tracker on an 8x4 frame: stimulus pushes
// hand-computed results, a monitor pops and compares on each accepted result.
module tb_motion_region_tracker;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = $clog2(H*V+1);

  typedef struct packed {
    logic [CW-1:0] count;
    logic [9:0]    xmin;
    logic [9:0]    xmax;
    logic [8:0]    ymin;
    logic [8:0]    ymax;
    logic          bv;
    logic          alarm;
    logic          ovr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t exp_q[$];

  motion_region_tracker_if #(.CW(CW)) bus ();

  motion_region_tracker #(
    .H_ACT(H), .V_ACT(V), .COUNT_THRESHOLD(19'd2), .HOLD_FRAMES(4'd3), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input int x0, input int x1, input int y0,
                      input int y1, input bit bv, input bit alarm, input bit ovr);
    res_t r;
    r.count = CW'(cnt);
    r.xmin  = 10'(x0);
    r.xmax  = 10'(x1);
    r.ymin  = 9'(y0);
    r.ymax  = 9'(y1);
    r.bv    = bv;
    r.alarm = alarm;
    r.ovr   = ovr;
    exp_q.push_back(r);
  endtask

  task automatic sof();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Drive n_pix raster pixels; optional frame_start / ready on the last one
  task automatic drive_pixels(input logic [31:0] mask, input int n_pix,
                              input bit sof_on_last, input bit ready_on_last);
    for (int i = 0; i < n_pix; i++) begin
      bus.pixel_valid = 1'b1;
      bus.motion_flag = mask[i];
      bus.frame_start = sof_on_last && (i == n_pix - 1);
      if (ready_on_last && i == n_pix - 1) bus.result_ready = 1'b1;
      tick();
    end
    bus.pixel_valid = 1'b0;
    bus.motion_flag = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".result_valid"}, 32'(bus.result_valid), 0);
    check({tag, ".motion_count"}, 32'(bus.motion_count), 0);
    check({tag, ".box_x_min"},    32'(bus.box_x_min), 0);
    check({tag, ".box_x_max"},    32'(bus.box_x_max), 0);
    check({tag, ".box_y_min"},    32'(bus.box_y_min), 0);
    check({tag, ".box_y_max"},    32'(bus.box_y_max), 0);
    check({tag, ".box_valid"},    32'(bus.box_valid), 0);
    check({tag, ".motion_alarm"}, 32'(bus.motion_alarm), 0);
    check({tag, ".overrun"},      32'(bus.overrun), 0);
  endtask

  // Monitor: every accepted result is compared against the scoreboard head
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.result_valid && bus.result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.motion_count), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("mon.motion_count", 32'(bus.motion_count), 32'(e.count));
          check("mon.box_x_min",    32'(bus.box_x_min),    32'(e.xmin));
          check("mon.box_x_max",    32'(bus.box_x_max),    32'(e.xmax));
          check("mon.box_y_min",    32'(bus.box_y_min),    32'(e.ymin));
          check("mon.box_y_max",    32'(bus.box_y_max),    32'(e.ymax));
          check("mon.box_valid",    32'(bus.box_valid),    32'(e.bv));
          check("mon.motion_alarm", 32'(bus.motion_alarm), 32'(e.alarm));
          check("mon.overrun",      32'(bus.overrun),      32'(e.ovr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start  = 1'b0;
    bus.pixel_valid  = 1'b0;
    bus.motion_flag  = 1'b0;
    bus.result_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Frame A: motion at (2,1),(5,3),(3,2) -> count 3 > 2, alarm set
    push(3, 2, 5, 1, 3, 1, 1, 0);
    sof();
    drive_pixels((32'd1 << 10) | (32'd1 << 29) | (32'd1 << 19), 32, 0, 0);
    check("latency.result_valid", 32'(bus.result_valid), 1);
    check("latency.motion_count", 32'(bus.motion_count), 3);

    // Three still frames: alarm decays 1,1,0
    push(0, 0, 0, 0, 0, 0, 1, 0);
    sof(); drive_pixels(32'd0, 32, 0, 0);
    push(0, 0, 0, 0, 0, 0, 1, 0);
    sof(); drive_pixels(32'd0, 32, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0);
    sof(); drive_pixels(32'd0, 32, 0, 0);

    // Short frame aborted by frame_start at (4,2); only frame C is reported
    sof();
    drive_pixels(32'd1 | (32'd1 << 11), 20, 0, 0);
    check("short.result_valid", 32'(bus.result_valid), 0);
    push(2, 4, 6, 1, 2, 1, 0, 0);
    sof();
    drive_pixels((32'd1 << 20) | (32'd1 << 14), 32, 0, 0);

    // D1 held unaccepted; D2 commits on the same edge D1 is accepted
    tick();
    bus.result_ready = 1'b0;
    push(3, 0, 2, 1, 1, 1, 1, 0);
    sof(); drive_pixels(32'h0000_0700, 32, 0, 0);
    push(1, 7, 7, 3, 3, 1, 1, 0);
    sof(); drive_pixels(32'h8000_0000, 32, 0, 1);
    check("coincident.result_valid", 32'(bus.result_valid), 1);
    check("coincident.overrun", 32'(bus.overrun), 0);
    check("coincident.motion_count", 32'(bus.motion_count), 1);
    tick();

    // Overrun: two frames with result_ready low, second overwrites first
    bus.result_ready = 1'b0;
    sof(); drive_pixels(32'h0000_0001, 32, 0, 0);
    push(3, 1, 7, 0, 3, 1, 1, 1);
    sof(); drive_pixels((32'd1 << 1) | (32'd1 << 22) | (32'd1 << 31), 32, 0, 0);
    check("overrun.result_valid", 32'(bus.result_valid), 1);
    check("overrun.overrun", 32'(bus.overrun), 1);
    tick();
    check("overrun.held_valid", 32'(bus.result_valid), 1);
    bus.result_ready = 1'b1;
    tick();
    check("overrun.drop_valid", 32'(bus.result_valid), 0);

    // Reset mid-frame clears everything; stray pixels before frame_start ignored
    sof();
    drive_pixels(32'hFFFF_FFFF, 10, 0, 0);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    tick();
    rst_n = 1'b1;
    drive_pixels(32'hFFFF_FFFF, 32, 0, 0);
    tick();
    check("stray.result_valid", 32'(bus.result_valid), 0);
    push(3, 0, 7, 0, 3, 1, 1, 0);
    sof(); drive_pixels(32'd1 | (32'd1 << 12) | (32'd1 << 31), 32, 0, 0);

    // frame_start on the last pixel of F: G runs without a separate pulse
    push(1, 5, 5, 0, 0, 1, 1, 0);
    sof(); drive_pixels(32'd1 << 5, 32, 1, 0);
    push(0, 0, 0, 0, 0, 0, 1, 0);
    drive_pixels(32'd0, 32, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
